// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer and EX divider handshake
// Merges load-use, divide and data-SRAM wait into one stall vector; sequences the divider.
module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             mem_wait,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [31:0]      div_src_a,
  input  logic [31:0]      div_src_b,
  input  logic             div_ready,
  input  logic [63:0]      div_result,
  output logic [5:0]       stall,
  output logic             div_start,
  output logic             div_signed_o,
  output logic [31:0]      div_opa,
  output logic [31:0]      div_opb,
  output logic [31:0]      div_hi,
  output logic [31:0]      div_lo,
  output logic             div_res_valid,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(DIV_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic              signed_q, signed_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      signed_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      signed_q  <= signed_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    signed_d  = signed_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        // MEM holding means EX cannot commit to the divide yet; wait in IDLE
        if (div_req && !mem_wait) begin
          state_d  = S_START;
          opa_d    = div_src_a;
          opb_d    = div_src_b;
          signed_d = div_signed;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (div_ready) begin
          state_d = S_DONE;
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
        end else if (wcnt_q == WCNT_W'(DIV_TIMEOUT - 1)) begin
          state_d   = S_DONE;
          hi_d      = '0;
          lo_d      = '0;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_DONE: begin
        // Always back to IDLE so the same instruction is never restarted
        if (!mem_wait) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_d = 6'b000000;
    if (mem_wait)
      stall_d = 6'b011111;
    else if (state_q == S_START || state_q == S_WAIT || (state_q == S_IDLE && div_req))
      stall_d = 6'b001111;
    else if (stallreq_from_id)
      stall_d = 6'b000111;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_d[0] && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  assign stall         = stall_d;
  assign div_start     = (state_q == S_START);
  assign div_res_valid = (state_q == S_DONE);
  assign div_signed_o  = signed_q;
  assign div_opa       = opa_q;
  assign div_opb       = opb_q;
  assign div_hi        = hi_q;
  assign div_lo        = lo_q;
  assign div_timeout   = timeout_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
// Behavioural divider answers div_start after a programmable latency; results go via a queue.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             stallreq_from_id;
  logic             mem_wait;
  logic             div_req;
  logic             div_signed;
  logic [31:0]      div_src_a;
  logic [31:0]      div_src_b;
  logic             div_ready;
  logic [63:0]      div_result;
  logic [5:0]       stall;
  logic             div_start;
  logic             div_signed_o;
  logic [31:0]      div_opa;
  logic [31:0]      div_opb;
  logic [31:0]      div_hi;
  logic [31:0]      div_lo;
  logic             div_res_valid;
  logic             div_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int total;
  int bad;
  int starts;
  int exp_cnt;
  int div_lat;
  logic [63:0] div_res_m;
  logic [63:0] exp_q[$];
  logic [63:0] exp_r;

  pipe_stall_ctrl #(.DIV_TIMEOUT(40), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_from_id(stallreq_from_id), .mem_wait(mem_wait),
    .div_req(div_req), .div_signed(div_signed), .div_src_a(div_src_a),
    .div_src_b(div_src_b), .div_ready(div_ready), .div_result(div_result),
    .stall(stall), .div_start(div_start), .div_signed_o(div_signed_o),
    .div_opa(div_opa), .div_opb(div_opb), .div_hi(div_hi), .div_lo(div_lo),
    .div_res_valid(div_res_valid), .div_timeout(div_timeout), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider model: div_ready pulses div_lat cycles after the START cycle; 0 = never
  initial begin : divider_model
    int cd;
    cd = 0;
    div_ready = 1'b0;
    div_result = '0;
    forever begin
      @(posedge clk); #1;
      div_ready = 1'b0;
      if (rst) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            div_ready = 1'b1;
            div_result = div_res_m;
          end
        end
        if (div_start === 1'b1 && div_lat > 0) cd = div_lat;
      end
    end
  end

  initial begin : start_monitor
    starts = 0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) starts++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    settle();
    total++; if (stall !== 6'b0) begin bad++; $display("FAIL por_stall: got %b want %b", stall, 6'b0); end
    total++; if (div_start !== 1'b0 || div_res_valid !== 1'b0) begin bad++; $display("FAIL por_ctl: got start=%b valid=%b want 0 0", div_start, div_res_valid); end
    total++; if (stall_cnt !== '0 || div_timeout !== 1'b0) begin bad++; $display("FAIL por_cnt: got cnt=%0d to=%b want 0 0", stall_cnt, div_timeout); end
    total++; if ({div_hi, div_lo, div_opa, div_opb} !== 128'd0) begin bad++; $display("FAIL por_data: got %h want 0", {div_hi, div_lo, div_opa, div_opb}); end
    // Abandon a divide mid-WAIT
    div_lat = 0; div_src_a = 32'd5; div_src_b = 32'd1; div_req = 1'b1;
    repeat (5) cyc();
    total++; if (stall !== 6'b001111) begin bad++; $display("FAIL rst_pre_wait: got %b want %b", stall, 6'b001111); end
    rst = 1'b1; div_req = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    settle();
    total++; if (stall !== 6'b0 || div_start !== 1'b0 || div_res_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_wait: got stall=%b start=%b valid=%b want 0", stall, div_start, div_res_valid); end
    total++; if (stall_cnt !== '0 || div_opa !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt: got cnt=%0d opa=%h want 0 0", stall_cnt, div_opa); end
    base = starts;
    repeat (3) cyc();
    settle();
    total++; if (starts != base || stall !== 6'b0) begin bad++; $display("FAIL rst_idle: got starts=%0d stall=%b want %0d 000000", starts - base, stall, 0); end
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    cyc(); stallreq_from_id = 1'b1; settle();
    total++; if (stall !== 6'b000111) begin bad++; $display("FAIL lu_stall: got %b want %b", stall, 6'b000111); end
    cyc(); stallreq_from_id = 1'b0; settle();
    total++; if (stall !== 6'b0) begin bad++; $display("FAIL lu_release: got %b want %b", stall, 6'b0); end
    exp_cnt = 1;
    total++; if (stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_divide();
    int base;
    int done_at;
    base = starts; done_at = -1;
    cyc();
    div_lat = 33; div_res_m = {32'd2, 32'd14};
    div_req = 1'b1; div_signed = 1'b1; div_src_a = 32'd100; div_src_b = 32'd7;
    exp_q.push_back(div_res_m);
    settle();
    total++; if (stall !== 6'b001111) begin bad++; $display("FAIL div_req_stall: got %b want %b", stall, 6'b001111); end
    for (int i = 1; i < 60 && done_at < 0; i++) begin
      cyc(); settle();
      if (div_res_valid === 1'b1) begin
        done_at = i;
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL div_sb: got empty queue want entry"); end
        else begin
          exp_r = exp_q.pop_front();
          total++; if ({div_hi, div_lo} !== exp_r) begin bad++; $display("FAIL div_result: got %h want %h", {div_hi, div_lo}, exp_r); end
        end
        total++; if (stall !== 6'b0) begin bad++; $display("FAIL div_done_stall: got %b want %b", stall, 6'b0); end
      end else begin
        total++; if (stall !== 6'b001111) begin bad++; $display("FAIL div_busy_stall: cycle %0d got %b want %b", i, stall, 6'b001111); end
      end
    end
    total++; if (done_at != 35) begin bad++; $display("FAIL div_latency: got %0d want %0d", done_at, 35); end
    total++; if (div_opa !== 32'd100 || div_opb !== 32'd7 || div_signed_o !== 1'b1) begin bad++; $display("FAIL div_ops: got %0d %0d %b want 100 7 1", div_opa, div_opb, div_signed_o); end
    cyc(); div_req = 1'b0; settle();
    total++; if (div_res_valid !== 1'b0 || stall !== 6'b0) begin bad++; $display("FAIL div_after: got valid=%b stall=%b want 0 000000", div_res_valid, stall); end
    total++; if (starts - base != 1) begin bad++; $display("FAIL div_starts: got %0d want 1", starts - base); end
    exp_cnt += 35;
    total++; if (stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL div_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_wait();
    int base;
    logic [5:0] es;
    logic ev;
    base = starts;
    div_lat = 10; div_res_m = {32'd0, 32'd10};
    div_signed = 1'b0; div_src_a = 32'd50; div_src_b = 32'd5;
    for (int i = 0; i <= 17; i++) begin
      cyc();
      mem_wait = (i == 0) || (i >= 5 && i <= 7) || (i >= 13 && i <= 15);
      div_req = (i <= 16);
      if (i == 0) exp_q.push_back(div_res_m);
      settle();
      es = mem_wait ? 6'b011111 : (i <= 12 ? 6'b001111 : 6'b000000);
      ev = (i >= 13 && i <= 16);
      total++; if (stall !== es) begin bad++; $display("FAIL mw_stall: cycle %0d got %b want %b", i, stall, es); end
      total++; if (div_res_valid !== ev) begin bad++; $display("FAIL mw_valid: cycle %0d got %b want %b", i, div_res_valid, ev); end
      total++; if (div_start !== (i == 2)) begin bad++; $display("FAIL mw_start: cycle %0d got %b want %b", i, div_start, (i == 2)); end
      if (i == 13) begin
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL mw_sb: got empty queue want entry"); end
        else begin
          exp_r = exp_q.pop_front();
          total++; if ({div_hi, div_lo} !== exp_r) begin bad++; $display("FAIL mw_result: got %h want %h", {div_hi, div_lo}, exp_r); end
        end
      end
      if (i == 16) begin
        total++; if ({div_hi, div_lo} !== {32'd0, 32'd10}) begin bad++; $display("FAIL mw_hold: got %h want %h", {div_hi, div_lo}, {32'd0, 32'd10}); end
      end
    end
    mem_wait = 1'b0;
    total++; if (starts - base != 1) begin bad++; $display("FAIL mw_starts: got %0d want 1", starts - base); end
    exp_cnt += 16;
    total++; if (stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL mw_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    int done_at;
    done_at = -1;
    cyc();
    div_lat = 0; div_req = 1'b1; div_signed = 1'b1; div_src_a = 32'd77; div_src_b = 32'd3;
    exp_q.push_back(64'd0);
    settle();
    for (int i = 1; i < 70 && done_at < 0; i++) begin
      cyc(); settle();
      if (div_res_valid === 1'b1) begin
        done_at = i;
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL to_sb: got empty queue want entry"); end
        else begin
          exp_r = exp_q.pop_front();
          total++; if ({div_hi, div_lo} !== exp_r) begin bad++; $display("FAIL to_result: got %h want %h", {div_hi, div_lo}, exp_r); end
        end
        total++; if (div_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", div_timeout); end
      end else begin
        total++; if (div_timeout !== 1'b0 || stall !== 6'b001111) begin bad++; $display("FAIL to_wait: cycle %0d got to=%b stall=%b want 0 001111", i, div_timeout, stall); end
      end
    end
    total++; if (done_at != 42) begin bad++; $display("FAIL to_latency: got %0d want %0d", done_at, 42); end
    cyc(); div_req = 1'b0; settle();
    // A good divide afterwards must not clear the sticky flag
    done_at = -1;
    cyc();
    div_lat = 5; div_res_m = {32'd1, 32'd4};
    div_req = 1'b1; div_signed = 1'b0; div_src_a = 32'd9; div_src_b = 32'd2;
    exp_q.push_back(div_res_m);
    settle();
    for (int i = 1; i < 30 && done_at < 0; i++) begin
      cyc(); settle();
      if (div_res_valid === 1'b1) begin
        done_at = i;
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL to2_sb: got empty queue want entry"); end
        else begin
          exp_r = exp_q.pop_front();
          total++; if ({div_hi, div_lo} !== exp_r) begin bad++; $display("FAIL to2_result: got %h want %h", {div_hi, div_lo}, exp_r); end
        end
      end
    end
    total++; if (done_at != 7) begin bad++; $display("FAIL to2_latency: got %0d want %0d", done_at, 7); end
    cyc(); div_req = 1'b0; settle();
    total++; if (div_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", div_timeout); end
    exp_cnt += 49;
    total++; if (stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL to_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [5:0] es;
    logic [63:0] r1;
    logic [63:0] r2;
    base = starts;
    r1 = {32'd2, 32'd6};
    r2 = {32'hFFFF_FFFD, 32'hFFFF_FFFD};
    div_lat = 4;
    for (int i = 0; i <= 14; i++) begin
      cyc();
      stallreq_from_id = (i <= 13);
      div_req = (i <= 13);
      div_src_a = (i <= 6) ? 32'd20 : 32'hFFFF_FFF1;
      div_src_b = (i <= 6) ? 32'd3 : 32'd4;
      div_signed = (i > 6);
      div_res_m = (i <= 6) ? r1 : r2;
      if (i == 0) exp_q.push_back(r1);
      if (i == 7) exp_q.push_back(r2);
      settle();
      if (i == 14) es = 6'b000000;
      else if (i == 6 || i == 13) es = 6'b000111;
      else es = 6'b001111;
      total++; if (stall !== es) begin bad++; $display("FAIL b2b_stall: cycle %0d got %b want %b", i, stall, es); end
      total++; if (div_start !== (i == 1 || i == 8)) begin bad++; $display("FAIL b2b_start: cycle %0d got %b", i, div_start); end
      total++; if (div_res_valid !== (i == 6 || i == 13)) begin bad++; $display("FAIL b2b_valid: cycle %0d got %b", i, div_res_valid); end
      if (i == 6 || i == 13) begin
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL b2b_sb: got empty queue want entry"); end
        else begin
          exp_r = exp_q.pop_front();
          total++; if ({div_hi, div_lo} !== exp_r) begin bad++; $display("FAIL b2b_result: cycle %0d got %h want %h", i, {div_hi, div_lo}, exp_r); end
        end
      end
      if (i == 2) begin
        total++; if (div_opa !== 32'd20 || div_opb !== 32'd3 || div_signed_o !== 1'b0) begin bad++; $display("FAIL b2b_ops1: got %h %h %b want 00000014 00000003 0", div_opa, div_opb, div_signed_o); end
      end
      if (i == 9) begin
        total++; if (div_opa !== 32'hFFFF_FFF1 || div_opb !== 32'd4 || div_signed_o !== 1'b1) begin bad++; $display("FAIL b2b_ops2: got %h %h %b want fffffff1 00000004 1", div_opa, div_opb, div_signed_o); end
      end
    end
    total++; if (starts - base != 2) begin bad++; $display("FAIL b2b_starts: got %0d want 2", starts - base); end
    exp_cnt += 14;
    total++; if (stall_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 0;
    rst = 1'b1; stallreq_from_id = 1'b0; mem_wait = 1'b0; div_req = 1'b0;
    div_signed = 1'b0; div_src_a = '0; div_src_b = '0;
    div_lat = 0; div_res_m = '0;
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
